uart_tx_fifo: RTL and testbench

- Transmit-side buffer directly upstream of the UART core.
- Accepts bytes from a host write port into a DEPTH-entry FIFO.
- Drains the FIFO into the UART's tx_data/send/tx_data_ready handshake, one byte per UART frame.
- Lets the host burst bytes without polling tx_data_ready; reports fill level and sticky overflow.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_sync_fifo.sv | 72 +++++++
 rtl/uart_tx_fifo.sv | 101 ++++++++++
 tb/tb_uart_tx_fifo.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: the data byte and the transmit-buffer handshake states.
package uart_pkg;

  typedef logic [7:0] uart_data_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_READY
  } uart_tx_fifo_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous byte FIFO with flush; head byte is visible on dout.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  uart_data_t               din,
  output uart_data_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  uart_data_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;
  logic [AW:0]     level_next;

  always_comb begin
    push_ok    = push && !full && !flush;
    pop_ok     = pop && !empty;
    level_next = level;
    if (flush)
      level_next = '0;
    else if (push_ok && !pop_ok)
      level_next = level + (AW+1)'(1);
    else if (pop_ok && !push_ok)
      level_next = level - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= din;
  end

  // full/empty are registered alongside level so they never glitch on pointer math
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok)
          rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_next;
      full  <= (level_next == LVL_FULL);
      empty <= (level_next == '0);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the UART core: queues host bytes and feeds
// them one per frame through the send / tx_data_ready handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  uart_data_t               wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output uart_data_t               tx_data,
  output logic                     send,
  input  logic                     tx_data_ready
);

  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  uart_tx_fifo_state_t state;
  logic [CW-1:0]       cnt;
  logic                push;
  logic                pop;
  uart_data_t          head;

  assign push = wr_en && !flush;
  assign pop  = (state == IDLE) && !empty && tx_data_ready;

  uart_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (wr_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // A write into a full FIFO is lost even if a pop frees a slot this cycle
  always_ff @(posedge clk) begin
    if (rst)
      overflow <= 1'b0;
    else if (wr_en && full && !flush)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      send    <= 1'b0;
      tx_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= head;
            send    <= 1'b1;
            state   <= SEND;
          end else begin
            tx_data <= '0;
            send    <= 1'b0;
          end
        end
        SEND: begin
          send    <= 1'b0;
          tx_data <= '0;
          cnt     <= '0;
          state   <= WAIT_BUSY;
        end
        // A UART that never drops ready is assumed to have taken the byte
        WAIT_BUSY: begin
          if (!tx_data_ready || cnt == CNT_LAST)
            state <= WAIT_READY;
          else
            cnt <= cnt + CW'(1);
        end
        WAIT_READY: begin
          if (tx_data_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a queue-based reference model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AT    = 4;

  logic       clk = 1'b0;
  logic       rst, flush, wr_en, ovf_clr;
  logic       ready_man, uart_en;
  logic       ready_uart = 1'b1;
  logic       tx_data_ready;
  uart_data_t wr_data, tx_data;
  logic       full, empty, overflow, send;
  logic [2:0] level;

  assign tx_data_ready = uart_en ? ready_uart : ready_man;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (AT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .full          (full),
    .empty         (empty),
    .level         (level),
    .overflow      (overflow),
    .ovf_clr       (ovf_clr),
    .tx_data       (tx_data),
    .send          (send),
    .tx_data_ready (tx_data_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte queue, sticky overflow, and handshake pacing
  // (busy window of up to AT edges, then wait for ready before next pop).
  uart_data_t mq[$];
  logic       m_send = 1'b0;
  uart_data_t m_tx   = '0;
  logic       m_ovf  = 1'b0;
  int         m_win  = 0;
  bit         m_wait = 1'b0;
  bit         m_idle, m_full_pre, m_pop;
  uart_data_t m_head;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      m_send = 1'b0;
      m_tx   = '0;
      m_ovf  = 1'b0;
      m_win  = 0;
      m_wait = 1'b0;
    end else begin
      m_idle     = !m_send && !m_wait;
      m_full_pre = (mq.size() == DEPTH);
      m_pop      = m_idle && (mq.size() != 0) && tx_data_ready;
      m_head     = m_pop ? mq[0] : 8'h00;
      if (m_send) begin
        m_win  = AT;
        m_wait = 1'b1;
      end else if (m_wait && m_win > 0) begin
        if (!tx_data_ready || m_win == 1) m_win = 0;
        else m_win--;
      end else if (m_wait && tx_data_ready) begin
        m_wait = 1'b0;
      end
      if (m_pop) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (wr_en && !m_full_pre) mq.push_back(wr_data);
      if (wr_en && m_full_pre && !flush) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_send = m_pop;
      m_tx   = m_head;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("send",     int'(send),     int'(m_send));
      check("tx_data",  int'(tx_data),  int'(m_tx));
      check("level",    int'(level),    mq.size());
      check("full",     int'(full),     int'(mq.size() == DEPTH));
      check("empty",    int'(empty),    int'(mq.size() == 0));
      check("overflow", int'(overflow), int'(m_ovf));
    end
  end

  uart_data_t sent[$];
  int         sent_cyc[$];
  int         ut = -1;

  always @(negedge clk) begin
    if (send) begin
      sent.push_back(tx_data);
      sent_cyc.push_back(cyc);
    end
    if (uart_en) begin
      if (send) ut = 0;
      else if (ut >= 0) begin
        ut++;
        if (ut == 2) ready_uart = 1'b0;
        if (ut == 12) begin
          ready_uart = 1'b1;
          ut = -1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input uart_data_t d);
    wr_en   = 1'b1;
    wr_data = d;
    step(1);
    wr_en   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; wr_en = 1'b1; wr_data = 8'hFF;
    ovf_clr = 1'b0; ready_man = 1'b0; uart_en = 1'b0;
    step(2);
    rst = 1'b0; wr_en = 1'b0;
    chk_en = 1'b1;
    check("rst_level", int'(level), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_send", int'(send), 0);
    check("rst_tx", int'(tx_data), 0);
    step(1);

    // single byte
    ready_man = 1'b1;
    wr(8'hA5);
    check("single_level_after_wr", int'(level), 1);
    check("single_send_early", int'(send), 0);
    step(1);
    check("single_send", int'(send), 1);
    check("single_tx", int'(tx_data), 8'hA5);
    check("single_level", int'(level), 0);
    check("single_empty", int'(empty), 1);
    step(1);
    check("single_send_drop", int'(send), 0);
    step(10);

    // back-pressure and overflow
    ready_man = 1'b0;
    for (int i = 1; i <= 4; i++) wr(uart_data_t'(i));
    check("bp_full", int'(full), 1);
    check("bp_level", int'(level), 4);
    wr(8'h05);
    check("bp_ovf", int'(overflow), 1);
    check("bp_level_after_drop", int'(level), 4);
    sent.delete();
    ready_uart = 1'b1;
    uart_en = 1'b1;
    for (int i = 0; i < 400 && sent.size() < 4; i++) step(1);
    step(30);
    check("bp_count", sent.size(), 4);
    for (int i = 0; i < 4 && i < sent.size(); i++)
      check("bp_order", int'(sent[i]), i + 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("bp_ovf_clr", int'(overflow), 0);
    step(20);

    // timeout pacing with ready stuck high
    uart_en = 1'b0;
    ready_man = 1'b1;
    sent.delete();
    sent_cyc.delete();
    wr(8'h10); wr(8'h20); wr(8'h30);
    for (int i = 0; i < 100 && sent.size() < 3; i++) step(1);
    check("to_count", sent.size(), 3);
    if (sent.size() >= 3) begin
      check("to_d0", int'(sent[0]), 8'h10);
      check("to_d1", int'(sent[1]), 8'h20);
      check("to_d2", int'(sent[2]), 8'h30);
      check("to_gap01", sent_cyc[1] - sent_cyc[0], AT + 3);
      check("to_gap12", sent_cyc[2] - sent_cyc[1], AT + 3);
    end
    step(10);

    // flush with a same-cycle write
    ready_man = 1'b0;
    wr(8'h31); wr(8'h32); wr(8'h33);
    check("fl_level3", int'(level), 3);
    flush = 1'b1;
    wr(8'h77);
    flush = 1'b0;
    check("fl_level0", int'(level), 0);
    check("fl_empty", int'(empty), 1);
    check("fl_ovf", int'(overflow), 0);
    n = sent.size();
    ready_man = 1'b1;
    step(20);
    check("fl_no_send", sent.size(), n);

    // flush while full does not flag overflow
    ready_man = 1'b0;
    for (int i = 0; i < 4; i++) wr(uart_data_t'(8'h41 + i));
    check("flf_full", int'(full), 1);
    flush = 1'b1;
    wr(8'h45);
    flush = 1'b0;
    check("flf_ovf", int'(overflow), 0);
    check("flf_level", int'(level), 0);
    ready_man = 1'b1;
    step(10);

    // pop and write in the same cycle
    ready_man = 1'b0;
    step(2);
    wr(8'h51);
    check("pw_level1", int'(level), 1);
    ready_man = 1'b1;
    wr(8'h52);
    check("pw_level_hold", int'(level), 1);
    check("pw_send", int'(send), 1);
    check("pw_tx", int'(tx_data), 8'h51);
    step(20);

    // pop and flush in the same cycle still sends
    ready_man = 1'b0;
    wr(8'h61);
    ready_man = 1'b1;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("pf_send", int'(send), 1);
    check("pf_tx", int'(tx_data), 8'h61);
    check("pf_level", int'(level), 0);
    step(20);

    // randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      wr_en     = ($urandom_range(0, 2) != 0);
      wr_data   = uart_data_t'($urandom_range(0, 255));
      ready_man = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 60) == 0);
      ovf_clr   = ($urandom_range(0, 25) == 0);
      step(1);
    end
    wr_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0; ready_man = 1'b1;
    step(40);
    check("end_empty", int'(empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
